hazard_ctrl_unit: RTL and testbench
===================================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 clk  input  1  core clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 id_rs1_addr, id_rs2_addr  input  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  instruction in ID reads rs1 / rs2.
REQ-006 id_is_muldiv  input  1  instruction in ID is a multi-cycle M-extension op.
REQ-007 ex_mem_read  input  1  instruction in EX is a load.
REQ-008 ex_rd_addr  input  5  destination register of the instruction in EX.
REQ-009 ex_branch_taken  input  1  EX resolves a taken branch or jump (PC redirect).
REQ-010 md_done  input  1  single-cycle pulse from the multi-cycle unit, result written.
REQ-011 pc_write_en, if_id_write_en  output  1 each  front-end advance enables.
REQ-012 if_id_flush, id_ex_flush  output  1 each  insert bubble into IF/ID / ID/EX.
REQ-013 md_start  output  1  single-cycle launch pulse to the multi-cycle unit.
REQ-014 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-015 The FSM SHALL have states IDLE, MD_BUSY and MD_RETIRE; all control outputs are combinational from state and inputs.
REQ-016 Default (IDLE, no event): pc_write_en=1, if_id_write_en=1, both flushes=0, md_start=0.
REQ-017 Load-use: ex_mem_read=1, ex_rd_addr!=0, and (id_uses_rs1 with rs1==ex_rd_addr or id_uses_rs2 with rs2==ex_rd_addr) SHALL give pc_write_en=0, if_id_write_en=0, id_ex_flush=1 for exactly that cycle.
REQ-018 ex_branch_taken=1 SHALL give if_id_flush=1, id_ex_flush=1, pc_write_en=1, and SHALL override load-use and muldiv issue in the same cycle.
REQ-019 In IDLE with id_is_muldiv=1 and neither branch nor load-use, md_start SHALL pulse 1, the front end SHALL stall (write enables 0, id_ex_flush=1), and the next state is MD_BUSY.
REQ-020 In MD_BUSY, front end stalled and id_ex_flush=1 every cycle; md_done=1 moves to MD_RETIRE; md_start stays 0.
REQ-021 In MD_RETIRE, pc_write_en=1, if_id_write_en=1, id_ex_flush=1 (muldiv never enters EX); next state is IDLE.
REQ-022 md_done in IDLE or MD_RETIRE SHALL be ignored; ex_branch_taken in MD_BUSY/MD_RETIRE SHALL be ignored (EX holds bubbles).
REQ-023 stall_cnt SHALL increment on every cycle with pc_write_en=0 and saturate at 2^CNT_W-1.
REQ-024 flush_cnt SHALL increment on every cycle with if_id_flush=1 and saturate at 2^CNT_W-1.
REQ-025 Total stall of a muldiv with md_done N cycles after md_start SHALL be N+1 cycles (issue cycle plus MD_BUSY cycles).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, stall_cnt=0, flush_cnt=0, md_start=0, with write enables 1 and flushes 0 while held.
REQ-027 Reset asserted in MD_BUSY SHALL abandon the operation; no md_start on release unless a new muldiv is in ID.

Structure
REQ-028 State enum hazard_state_e (IDLE, MD_BUSY, MD_RETIRE) SHALL live in package defines.
REQ-029 One sub-module sat_counter (parameter W, inputs clk, rst_n, inc; output count) SHALL be instantiated twice.

Verification
REQ-030 Load-use: ex_mem_read=1, ex_rd=5, id rs1=5 uses_rs1=1 -> one cycle pc_write_en=0, id_ex_flush=1; stall_cnt=1.
REQ-031 Branch plus load-use same cycle -> if_id_flush=1, pc_write_en=1; flush_cnt=1, stall_cnt unchanged.
REQ-032 Muldiv with md_done 4 cycles after md_start -> md_start high exactly 1 cycle, 5 stall cycles, then one MD_RETIRE cycle, then IDLE.
REQ-033 ex_rd=0 with matching rs1=0 and load -> no stall.
REQ-034 Force 70000 stall cycles with CNT_W=16 -> stall_cnt holds 65535.
REQ-035 Reset pulse in MD_BUSY -> IDLE, counters 0, spurious md_done afterwards ignored.

Source files
------------

// File: rtl/defines.sv
// ---------------------------------------------------------------------------
// defines -- shared types and helpers for the pipeline hazard control unit.
//
// Contents:
//   hazard_state_e : FSM state encoding (IDLE, MD_BUSY, MD_RETIRE)
//   REG_ADDR_W     : architectural register address width
//   reg_match()    : true when a used source register matches a destination
// ---------------------------------------------------------------------------
package defines;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MD_BUSY   = 2'd1,
        MD_RETIRE = 2'd2
    } hazard_state_e;

    function automatic logic reg_match(
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter -- W-bit event counter that sticks at its all-ones maximum.
//
// Ports:
//   clk   : clock, count updates on rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count this cycle
//   count : current count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit -- pipeline hazard controller: load-use stalls, branch
// flushes and issue/stall sequencing for a multi-cycle mul/div unit, plus
// saturating stall and flush performance counters.
//
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   id_rs1_addr/id_rs2_addr        : ID-stage source registers
//   id_uses_rs1/id_uses_rs2        : ID instruction reads rs1 / rs2
//   id_is_muldiv                   : ID instruction is a multi-cycle M op
//   ex_mem_read, ex_rd_addr        : EX instruction is a load, its rd
//   ex_branch_taken                : EX redirects the PC
//   md_done                        : multi-cycle unit finished (pulse)
//   pc_write_en, if_id_write_en    : front-end advance enables
//   if_id_flush, id_ex_flush       : bubble insertion
//   md_start                       : multi-cycle unit launch (pulse)
//   stall_cnt, flush_cnt           : saturating event counters
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
    import defines::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_is_muldiv,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_branch_taken,
    input  logic             md_done,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_start,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_state_e state, state_next;
    logic          load_use;

    // x0 is hardwired zero, so a load "to" x0 never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd_addr != '0) &&
                      (reg_match(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                       reg_match(id_uses_rs2, id_rs2_addr, ex_rd_addr));

    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        md_start       = 1'b0;
        state_next     = state;

        // While reset is held the outputs stay at their run defaults even
        // though the inputs may be showing arbitrary pipeline contents.
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    // Redirect wins: the instructions in IF/ID are wrong-path.
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_flush    = 1'b1;
                    end else if (id_is_muldiv) begin
                        md_start       = 1'b1;
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_flush    = 1'b1;
                        state_next     = MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    // EX only holds bubbles here, so a branch cannot resolve.
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_flush    = 1'b1;
                    if (md_done) begin
                        state_next = MD_RETIRE;
                    end
                end
                MD_RETIRE: begin
                    // The mul/div already wrote its result; it must not also
                    // flow into EX, so it is replaced by a bubble as it leaves.
                    id_ex_flush = 1'b1;
                    state_next  = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // NOTE: only control state is reset; the asynchronous reset abandons any
    // in-flight mul/div because the FSM simply returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_write_en),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit -- self-checking bench for hazard_ctrl_unit.
// Expected control-output vectors are queued as each stimulus cycle is
// driven and compared on the following falling edge.
// Output vector order: {pc_write_en, if_id_write_en, if_id_flush,
//                       id_ex_flush, md_start}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    localparam int CNT_W = 16;

    localparam logic [4:0] O_RUN    = 5'b11000;
    localparam logic [4:0] O_STALL  = 5'b00010;
    localparam logic [4:0] O_FLUSH  = 5'b11110;
    localparam logic [4:0] O_START  = 5'b00011;
    localparam logic [4:0] O_RETIRE = 5'b11010;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic             id_uses_rs1, id_uses_rs2, id_is_muldiv;
    logic             ex_mem_read, ex_branch_taken, md_done;
    logic             pc_write_en, if_id_write_en, if_id_flush, id_ex_flush;
    logic             md_start;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [4:0]       outs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    assign outs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, md_start};

    hazard_ctrl_unit #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_is_muldiv    (id_is_muldiv),
        .ex_mem_read     (ex_mem_read),
        .ex_rd_addr      (ex_rd_addr),
        .ex_branch_taken (ex_branch_taken),
        .md_done         (md_done),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .md_start        (md_start),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic md, input logic br, input logic done);
        ex_mem_read     = mr;
        ex_rd_addr      = rd;
        id_rs1_addr     = rs1;
        id_uses_rs1     = u1;
        id_rs2_addr     = rs2;
        id_uses_rs2     = u2;
        id_is_muldiv    = md;
        ex_branch_taken = br;
        md_done         = done;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue the expected vector for the cycle being driven, compare it at the
    // falling edge, then move to just after the next rising edge.
    task automatic step(input string tag, input logic [4:0] exp);
        logic [4:0] e;
        string      t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {27'd0, outs}, {27'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag, input int s, input int f);
        check({tag, "_stall_cnt"}, {16'd0, stall_cnt}, s);
        check({tag, "_flush_cnt"}, {16'd0, flush_cnt}, f);
    endtask

    initial begin
        // Reset held with hazardous inputs present: outputs stay at defaults.
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        #3;
        check("reset_outs", {27'd0, outs}, {27'd0, O_RUN});
        check_cnts("reset", 0, 0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step("idle_default", O_RUN);
        check_cnts("idle", 0, 0);

        // Load-use on rs1
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("load_use_rs1", O_STALL);
        check_cnts("load_use_rs1", 1, 0);
        idle();
        step("after_load_use", O_RUN);

        // Load-use on rs2, then same match with uses_rs2 clear
        drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("load_use_rs2", O_STALL);
        drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rs2_unused", O_RUN);
        check_cnts("rs2", 2, 0);

        // Load to x0 never stalls
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("load_x0", O_RUN);
        // Non-load with a matching rd does not stall either
        drive(1'b0, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("no_load_match", O_RUN);
        check_cnts("x0", 2, 0);

        // Branch overrides load-use
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("branch_over_load", O_FLUSH);
        check_cnts("branch_load", 2, 1);

        // Branch overrides muldiv issue; FSM stays in IDLE
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        step("branch_over_md", O_FLUSH);
        idle();
        step("after_branch_md", O_RUN);
        check_cnts("branch_md", 2, 2);

        // Load-use overrides muldiv issue
        drive(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("load_over_md", O_STALL);
        idle();
        step("after_load_md", O_RUN);
        check_cnts("load_md", 3, 2);

        // md_done in IDLE is ignored
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("done_in_idle", O_RUN);
        idle();
        step("after_done_idle", O_RUN);

        // Muldiv with md_done 4 cycles after md_start; a branch during BUSY
        // is ignored.
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step("md_issue", O_START);
        step("md_busy1", O_STALL);
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        step("md_busy2_branch", O_STALL);
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step("md_busy3", O_STALL);
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        step("md_busy4_done", O_STALL);
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        step("md_retire", O_RETIRE);
        idle();
        step("md_back_idle", O_RUN);
        check_cnts("muldiv", 8, 2);

        // Reset asserted in MD_BUSY abandons the operation
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("rst_md_issue", O_START);
        step("rst_md_busy", O_STALL);
        drive(1'b0, 5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_busy_outs", {27'd0, outs}, {27'd0, O_RUN});
        check_cnts("rst_busy", 0, 0);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("spurious_done", O_RUN);
        idle();
        step("post_rst_idle", O_RUN);
        check_cnts("post_rst", 0, 0);

        // Stall-counter saturation under a held load-use hazard
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_65534", {16'd0, stall_cnt}, 65534);
        @(posedge clk);
        #1;
        check("sat_65535", {16'd0, stall_cnt}, 65535);
        repeat (70000 - 65535) @(posedge clk);
        #1;
        check("sat_hold", {16'd0, stall_cnt}, 65535);
        check("sat_outs", {27'd0, outs}, {27'd0, O_STALL});
        check("sat_flush_cnt", {16'd0, flush_cnt}, 0);

        idle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
